adder_arbiter: RTL and testbench

Round-robin scheduler that shares a single 16-bit ripple adder (`Adder_16bit`) among `NREQ` requesters in the TPU datapath. Each requester issues either a narrow (16-bit) or a wide (32-bit) add over a valid/ready handshake. A wide add is sequenced as two passes through the same adder, with the carry chained through a register. Results return on one shared response bus, tagged with the requester ID.

---
 rtl/adder_arb_pkg.sv | 7 +
 rtl/adder_arbiter_adder.sv | 17 +
 rtl/adder_arbiter_rr_pick.sv | 24 ++
 rtl/adder_arbiter.sv | 112 +++++++++++
 tb/tb_adder_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and widths for the shared-adder arbiter.
package adder_arb_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI} arb_state_t;
    localparam int DEF_NREQ = 4;
    localparam int OPW = 32;
    localparam int HALFW = 16;
endpackage

// File: rtl/adder_arbiter_adder.sv
// Adder_16bit: 16-bit ripple-carry adder shared by all requesters.
import adder_arb_pkg::*;
module Adder_16bit (
    input  logic [HALFW-1:0] A,
    input  logic [HALFW-1:0] B,
    input  logic             Cin,
    output logic [HALFW-1:0] S,
    output logic             Cout
);
    logic [HALFW:0] c;
    assign c[0] = Cin;
    for (genvar i = 0; i < HALFW; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign Cout = c[HALFW];
endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit at or above ptr with wrap.
import adder_arb_pkg::*;
module rr_pick #(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] pool;
    always_comb begin
        mask = req & ~((NREQ'(1) << ptr) - NREQ'(1));
        pool = |mask ? mask : req;
        gnt_idx = '0;
        for (int j = NREQ - 1; j >= 0; j--)
            if (pool[j]) gnt_idx = IDW'(j);
    end
    assign any = |req;
    assign gnt_onehot = any ? (NREQ'(1) << gnt_idx) : '0;
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 16-bit adder; wide adds take two passes
// with the carry chained through carry_q.
import adder_arb_pkg::*;
module adder_arbiter #(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_wide,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_sum,
    output logic              rsp_cout,
    output logic              rsp_wide
);
    arb_state_t       state;
    logic [IDW-1:0]   ptr;
    logic [OPW-1:0]   op_a, op_b, sel_a, sel_b;
    logic             op_cin, op_wide, sel_cin, sel_wide;
    logic [IDW-1:0]   op_id;
    logic [HALFW-1:0] sum_lo, add_a, add_b, add_s;
    logic             carry_q, add_cin, add_cout;
    logic [NREQ-1:0]  gnt_onehot;
    logic [IDW-1:0]   gnt_idx;
    logic             any;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req(req_valid), .ptr(ptr), .gnt_onehot(gnt_onehot), .gnt_idx(gnt_idx), .any(any)
    );

    assign req_ready = (state == IDLE && rst_n) ? gnt_onehot : '0;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_cin = 1'b0;
        sel_wide = 1'b0;
        for (int j = 0; j < NREQ; j++)
            if (gnt_idx == IDW'(j)) begin
                sel_a = req_a[OPW*j +: OPW];
                sel_b = req_b[OPW*j +: OPW];
                sel_cin = req_cin[j];
                sel_wide = req_wide[j];
            end
    end

    // The single adder sees the low halves in LO and the high halves plus chained carry in HI.
    assign add_a   = state == HI ? op_a[OPW-1:HALFW] : op_a[HALFW-1:0];
    assign add_b   = state == HI ? op_b[OPW-1:HALFW] : op_b[HALFW-1:0];
    assign add_cin = state == HI ? carry_q : op_cin;

    Adder_16bit u_add (.A(add_a), .B(add_b), .Cin(add_cin), .S(add_s), .Cout(add_cout));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_wide   <= 1'b0;
            op_id     <= '0;
            sum_lo    <= '0;
            carry_q   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_wide  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    op_a    <= sel_a;
                    op_b    <= sel_b;
                    op_cin  <= sel_cin;
                    op_wide <= sel_wide;
                    op_id   <= gnt_idx;
                    ptr     <= gnt_idx == IDW'(NREQ - 1) ? '0 : gnt_idx + IDW'(1);
                    state   <= LO;
                end
                LO: if (op_wide) begin
                    sum_lo  <= add_s;
                    carry_q <= add_cout;
                    state   <= HI;
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_sum   <= {HALFW'(0), add_s};
                    rsp_cout  <= add_cout;
                    rsp_id    <= op_id;
                    rsp_wide  <= op_wide;
                    state     <= IDLE;
                end
                HI: begin
                    rsp_valid <= 1'b1;
                    rsp_sum   <= {add_s, sum_lo};
                    rsp_cout  <= add_cout;
                    rsp_id    <= op_id;
                    rsp_wide  <= op_wide;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: table-driven vectors plus fairness, pointer-skip and reset sequences,
// responses matched against a queue of expected results.
module tb_adder_arbiter;
    localparam int N = 4;
    logic clk = 0, rst_n = 0;
    logic [N-1:0] req_valid = '0, req_ready, req_wide = '0, req_cin = '0;
    logic [N*32-1:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_cout, rsp_wide;
    logic [1:0] rsp_id;
    logic [31:0] rsp_sum;

    adder_arbiter #(.NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_wide(req_wide), .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_wide(rsp_wide)
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic w; logic [31:0] a; logic [31:0] b; logic c; logic [31:0] es; logic ec;} vec_t;
    typedef struct {int id; logic w; logic [31:0] s; logic co; int cyc;} exp_t;

    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0;
    vec_t tbl[8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void push_model(int id, logic w, logic [31:0] a, logic [31:0] b, logic c);
        logic [32:0] r;
        exp_t e;
        r = w ? ({1'b0, a} + {1'b0, b} + 33'(c)) : 33'({1'b0, a[15:0]} + {1'b0, b[15:0]} + 17'(c));
        e.id = id; e.w = w; e.co = w ? r[32] : r[16];
        e.s = w ? r[31:0] : {16'h0, r[15:0]};
        e.cyc = cyc + (w ? 3 : 2);
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_sum", rsp_sum, e.s);
                chk("rsp_cout", 32'(rsp_cout), 32'(e.co));
                chk("rsp_wide", 32'(rsp_wide), 32'(e.w));
                chk("rsp_latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic drive(input int id, input logic w, input logic [31:0] a, input logic [31:0] b, input logic c);
        req_valid[id] = 1'b1;
        req_wide[id] = w;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_cin[id] = c;
    endtask

    task automatic issue(input vec_t v, input bit push);
        bit ok;
        exp_t e;
        @(negedge clk);
        drive(v.id, v.w, v.a, v.b, v.c);
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready[v.id]) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no req_ready for id %0d, required a grant", v.id);
        end else begin
            chk("ready_onehot", 32'(req_ready), 32'(1) << v.id);
            e.id = v.id; e.w = v.w; e.s = v.es; e.co = v.ec; e.cyc = cyc + (v.w ? 3 : 2);
            if (push) q.push_back(e);
        end
        @(posedge clk);
        #1 req_valid[v.id] = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending responses, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{0, 1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
        tbl[1] = '{2, 1'b0, 32'h0000FFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};
        tbl[2] = '{1, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0};
        tbl[3] = '{1, 1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        tbl[4] = '{3, 1'b0, 32'hABCD1234, 32'h5555EDCC, 1'b0, 32'h00000000, 1'b1};
        tbl[5] = '{0, 1'b1, 32'h12345678, 32'h87654321, 1'b1, 32'h9999999A, 1'b0};
        tbl[6] = '{2, 1'b1, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[7] = '{3, 1'b1, 32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};

        req_valid = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_sum", rsp_sum, 32'h0);
        req_valid = '0;
        rst_n = 1'b1;

        foreach (tbl[k]) issue(tbl[k], 1'b1);
        drain();

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) drive(i, 1'b0, 32'h00001111 * (i + 1), 32'h0000F000, i[0]);
        for (int k = 0; k < 12; k++) begin
            #1;
            if (k % 2 == 0) begin
                chk("rr_grant", 32'(req_ready), 32'(1) << ((k / 2) % N));
                push_model((k / 2) % N, 1'b0, 32'h00001111 * ((k / 2) % N + 1), 32'h0000F000, (k / 2) % 2 == 1);
            end else begin
                chk("rr_busy_ready", 32'(req_ready), 32'h0);
            end
            @(negedge clk);
        end
        req_valid = '0;
        drain();
        chk("ptr_after_rr", 32'(dut.ptr), 32'd2);

        @(negedge clk);
        drive(1, 1'b0, 32'h00000123, 32'h00000456, 1'b0);
        drive(3, 1'b0, 32'h00008000, 32'h00008001, 1'b1);
        #1;
        chk("skip_first_grant", 32'(req_ready), 32'h8);
        push_model(3, 1'b0, 32'h00008000, 32'h00008001, 1'b1);
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1;
        chk("skip_busy_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        #1;
        chk("skip_second_grant", 32'(req_ready), 32'h2);
        push_model(1, 1'b0, 32'h00000123, 32'h00000456, 1'b0);
        @(negedge clk);
        req_valid[1] = 1'b0;
        drain();
        chk("ptr_after_skip", 32'(dut.ptr), 32'd2);

        issue('{1, 1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0}, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("in_hi_state", 32'(dut.state), 32'(2));
        rst_n = 1'b0;
        drive(0, 1'b0, 32'h1, 32'h1, 1'b0);
        #1;
        chk("ready_in_reset", 32'(req_ready), 32'h0);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_sum", rsp_sum, 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'h0);
        chk("rst_rsp_wide", 32'(rsp_wide), 32'h0);
        chk("rst_ptr", 32'(dut.ptr), 32'h0);
        req_valid = '0;
        rst_n = 1'b1;
        issue('{2, 1'b0, 32'h00001234, 32'h00004321, 1'b1, 32'h00005556, 1'b0}, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
